apb2_master_arbiter: RTL and testbench

Round-robin arbiter that shares one APB2 master port between NUM_REQ requesters, for example the host bridge and an on-FPGA test sequencer. It drives the PADDR/PSEL/PENABLE/PWRITE/PWDATA bus into tester slaves such as the I2C master tester, and returns PRDATA to the requester that was granted. It serialises accesses as a strict APB2 SETUP→ACCESS sequence, with no wait states because APB2 has no PREADY.

---
 rtl/apb2_master_arbiter.sv | 161 ++++++++++++++++
 tb/tb_apb2_master_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb2_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb2_master_arbiter
// Purpose  : Round-robin sharing of one APB2 master port among NUM_REQ
//            requesters; strict SETUP->ACCESS sequencing, no wait states.
// Revision : 1.0 - initial release
// ============================================================================
module apb2_master_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_BITS-1:0]           rsp_rdata,
  output logic [ADDR_BITS-1:0]           PADDR,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [DATA_BITS-1:0]           PWDATA,
  input  logic [DATA_BITS-1:0]           PRDATA
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int IDX_W = PTR_W + 1;
  localparam logic [PTR_W:0]   NUM_REQ_EXT = IDX_W'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [ADDR_BITS-1:0] paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DATA_BITS-1:0] pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [PTR_W:0]       idx_ext;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_found;
  logic [NUM_REQ-1:0]   win_oh;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;
  logic                 sel_write;

  // Scan upward from the priority pointer, wrapping, and keep the first hit.
  always_comb begin
    idx_ext   = '0;
    win_idx   = '0;
    win_found = 1'b0;
    win_oh    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_ext = {1'b0, ptr_q} + IDX_W'(k);
      if (idx_ext >= NUM_REQ_EXT) begin
        idx_ext = idx_ext - NUM_REQ_EXT;
      end
      if (!win_found && req_valid[idx_ext[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_ext[PTR_W-1:0];
      end
    end
    win_oh[win_idx] = win_found;
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_oh[k]) begin
        sel_addr  = sel_addr  | req_addr[k*ADDR_BITS +: ADDR_BITS];
        sel_wdata = sel_wdata | req_wdata[k*DATA_BITS +: DATA_BITS];
        sel_write = sel_write | req_write[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = '0;
    case (state_q)
      S_IDLE: begin
        if (!rst) begin
          req_ready = win_oh;
        end
        if (win_found) begin
          state_d  = S_SETUP;
          ptr_d    = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          grant_d  = win_oh;
          paddr_d  = sel_addr;
          pwrite_d = sel_write;
          pwdata_d = sel_wdata;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        state_d     = S_IDLE;
        rsp_valid_d = grant_q;
        if (!pwrite_q) begin
          rsp_rdata_d = PRDATA;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign PSEL      = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PENABLE   = (state_q == S_ACCESS);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb2_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb2_master_arbiter
// Purpose  : Scoreboard bench: transaction-level arbiter model feeds an
//            expected queue, a bus monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb2_master_arbiter;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
  logic [AW-1:0]   PADDR;
  logic            PSEL, PENABLE, PWRITE;

  apb2_master_arbiter #(.NUM_REQ(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            t;
    int            g;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  txn_t          exp_q[$];
  int            total = 0;
  int            bad   = 0;
  bit            mon_en = 1'b0;
  bit            prd_rand = 1'b1;
  int            dut_g[$];
  int            dut_t[$];
  logic [N-1:0]  acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bus monitor: compares the APB phases and response against the queue head.
  logic [DW-1:0] last_rdata = '0;
  logic [DW-1:0] cap = '0;
  bit            rst_pend = 1'b0;
  initial forever begin
    int d;
    @(negedge clk);
    if (mon_en) begin
      if (rst_pend) begin
        chk("reset_state", {32'd0, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata}, 64'd0);
        rst_pend = 1'b0;
      end
      d = (exp_q.size() > 0) ? cyc - exp_q[0].t : 0;
      case (d)
        1: begin
          chk("setup_phase", {62'd0, PSEL, PENABLE}, 64'd2);
          chk("setup_fields", {43'd0, PWRITE, PADDR, PWDATA}, {43'd0, exp_q[0].wr, exp_q[0].a, exp_q[0].d});
          chk("no_rsp_setup", {61'd0, rsp_valid}, 64'd0);
        end
        2: begin
          chk("access_phase", {62'd0, PSEL, PENABLE}, 64'd3);
          chk("access_fields", {43'd0, PWRITE, PADDR, PWDATA}, {43'd0, exp_q[0].wr, exp_q[0].a, exp_q[0].d});
          chk("no_rsp_access", {61'd0, rsp_valid}, 64'd0);
          cap = PRDATA;
        end
        3: begin
          chk("bus_released", {62'd0, PSEL, PENABLE}, 64'd0);
          chk("rsp_valid", {61'd0, rsp_valid}, 64'd1 << exp_q[0].g);
          if (!exp_q[0].wr) last_rdata = cap;
          chk("rsp_rdata", {56'd0, rsp_rdata}, {56'd0, last_rdata});
          void'(exp_q.pop_front());
        end
        default: begin
          chk("bus_idle", {62'd0, PSEL, PENABLE}, 64'd0);
          chk("no_rsp_idle", {61'd0, rsp_valid}, 64'd0);
        end
      endcase
      if (rst) begin
        last_rdata = '0;
        rst_pend   = 1'b1;
      end
    end
  end

  // Reference arbiter: one transfer at a time, round-robin from ptr_m.
  int ptr_m = 0;
  initial forever begin
    int w;
    int idx;
    txn_t tx;
    @(negedge clk);
    #1;
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
        ptr_m = 0;
        chk("ready_in_reset", {61'd0, req_ready}, 64'd0);
      end else begin
        w = -1;
        if (exp_q.size() == 0) begin
          for (int k = 0; k < N; k++) begin
            idx = (ptr_m + k) % N;
            if (w < 0 && req_valid[idx]) w = idx;
          end
        end
        chk("req_ready", {61'd0, req_ready}, (w >= 0) ? (64'd1 << w) : 64'd0);
        if (w >= 0) begin
          tx.t  = cyc;
          tx.g  = w;
          tx.wr = req_write[w];
          tx.a  = req_addr[w*AW +: AW];
          tx.d  = req_wdata[w*DW +: DW];
          exp_q.push_back(tx);
          ptr_m = (w + 1) % N;
        end
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
    acc = req_ready;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) begin
        dut_g.push_back(k);
        dut_t.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
    if (prd_rand) PRDATA = DW'($urandom);
  endtask

  task automatic set_req(input int n, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[n]          = wr;
    req_addr[n*AW +: AW]  = a;
    req_wdata[n*DW +: DW] = d;
    req_valid[n]          = 1'b1;
  endtask

  task automatic clear_log();
    dut_g.delete();
    dut_t.delete();
  endtask

  initial begin
    int issued;
    rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; PRDATA = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    cycle();
    rst = 1'b0;
    clear_log();

    // Single write
    set_req(0, 1'b1, 12'd14, 8'hAA);
    repeat (5) cycle();
    chk("t1_count", 64'(dut_g.size()), 64'd1);
    if (dut_g.size() > 0) chk("t1_grant", 64'(dut_g[0]), 64'd0);

    // Single read then a write that must not disturb rsp_rdata
    prd_rand = 1'b0;
    PRDATA = 8'h32;
    set_req(1, 1'b0, 12'd21, 8'h00);
    repeat (5) cycle();
    chk("t2_rdata", {56'd0, rsp_rdata}, 64'h32);
    PRDATA = 8'h99;
    set_req(1, 1'b1, 12'd22, 8'h55);
    repeat (5) cycle();
    chk("t2_rdata_hold", {56'd0, rsp_rdata}, 64'h32);
    prd_rand = 1'b1;

    // Contention between req0 and req1
    clear_log();
    issued = 2;
    set_req(0, 1'b1, 12'h100, 8'h01);
    set_req(1, 1'b1, 12'h200, 8'h02);
    for (int i = 0; i < 20; i++) begin
      cycle();
      for (int n = 0; n < 2; n++) begin
        if (acc[n] && issued < 4) begin
          set_req(n, 1'b1, req_addr[n*AW +: AW] + 12'd1, DW'($urandom));
          issued++;
        end
      end
    end
    chk("t3_count", 64'(dut_g.size()), 64'd4);
    if (dut_g.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t3_order", 64'(dut_g[i]), 64'(i % 2));
      for (int i = 0; i < 3; i++) chk("t3_spacing", 64'(dut_t[i+1] - dut_t[i]), 64'd3);
    end

    // Wrap and skip from ptr=0
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_log();
    set_req(2, 1'b0, 12'h030, 8'h00);
    repeat (3) cycle();
    set_req(0, 1'b1, 12'h031, 8'h11);
    set_req(2, 1'b1, 12'h032, 8'h22);
    repeat (8) cycle();
    chk("t4_count", 64'(dut_g.size()), 64'd3);
    if (dut_g.size() >= 3) begin
      chk("t4_first", 64'(dut_g[0]), 64'd2);
      chk("t4_second", 64'(dut_g[1]), 64'd0);
      chk("t4_third", 64'(dut_g[2]), 64'd2);
      chk("t4_spacing", 64'(dut_t[1] - dut_t[0]), 64'd3);
    end

    // Reset during ACCESS of a read
    set_req(1, 1'b0, 12'h044, 8'h00);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    @(negedge clk);
    chk("t5_abort", {32'd0, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    set_req(0, 1'b1, 12'h050, 8'h05);
    set_req(1, 1'b1, 12'h051, 8'h06);
    repeat (8) cycle();
    if (dut_g.size() > 0) chk("t5_first_after_reset", 64'(dut_g[0]), 64'd0);
    else chk("t5_count", 64'd0, 64'd2);

    // Cancelled request leaves no trace
    clear_log();
    set_req(0, 1'b1, 12'h060, 8'h66);
    cycle();
    set_req(1, 1'b0, 12'h061, 8'h00);
    cycle();
    req_valid[1] = 1'b0;
    repeat (5) cycle();
    chk("t6_count", 64'(dut_g.size()), 64'd1);

    // Randomised traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < N; n++) begin
        if (!req_valid[n] && $urandom_range(0, 2) == 0)
          set_req(n, 1'($urandom), AW'($urandom), DW'($urandom));
        else if (req_valid[n] && $urandom_range(0, 15) == 0)
          req_valid[n] = 1'b0;
      end
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (6) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
